// File: rtl/xyz_reg_pkg.sv
// Shared constants, FSM state type and byte-merge helper for the XYZ register responder.
package xyz_reg_pkg;

    localparam logic [7:0] ADDR_R1   = 8'h00;
    localparam logic [7:0] ADDR_R2   = 8'h04;
    localparam logic [7:0] ADDR_CTRL = 8'h08;
    localparam logic [7:0] ADDR_ID   = 8'h0C;

    localparam logic [1:0] SEL_R1   = 2'd0;
    localparam logic [1:0] SEL_R2   = 2'd1;
    localparam logic [1:0] SEL_CTRL = 2'd2;
    localparam logic [1:0] SEL_ID   = 2'd3;

    typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

    function automatic logic [31:0] apply_be(input logic [31:0] old_w,
                                             input logic [31:0] new_w,
                                             input logic [3:0]  be);
        logic [31:0] res;
        res = old_w;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) res[8*i +: 8] = new_w[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/xyz_reg_decode.sv
// Combinational decode of a byte address into a register select; unknown or misaligned addresses flag err.
module xyz_reg_decode
    import xyz_reg_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic [ADDR_W-1:0] addr,
    output logic [1:0]        sel,
    output logic              err
);

    // Map constants are word aligned, so any addr[1:0] != 0 falls through to err.
    always_comb begin
        sel = SEL_R1;
        err = 1'b0;
        if (addr == ADDR_W'(ADDR_R1))        sel = SEL_R1;
        else if (addr == ADDR_W'(ADDR_R2))   sel = SEL_R2;
        else if (addr == ADDR_W'(ADDR_CTRL)) sel = SEL_CTRL;
        else if (addr == ADDR_W'(ADDR_ID))   sel = SEL_ID;
        else                                 err = 1'b1;
    end

endmodule

// File: rtl/xyz_reg_responder.sv
// Frontdoor responder for R1/R2/CTRL/ID; response WAIT_CYCLES+1 cycles after the request handshake.
// One transaction outstanding: req_ready is low from acceptance until the response is consumed.
module xyz_reg_responder
    import xyz_reg_pkg::*;
#(
    parameter int          ADDR_W      = 8,
    parameter logic [31:0] R1_RST      = 32'h0000_0000,
    parameter logic [31:0] R2_RST      = 32'h0000_0000,
    parameter int          WAIT_CYCLES = 1,
    parameter logic [31:0] ID_VALUE    = 32'h5859_5A01
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [3:0]        req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [31:0]       r1_q,
    output logic [31:0]       r2_q
);

    state_t            state;
    logic [3:0]        wait_cnt;
    logic              lat_write;
    logic [ADDR_W-1:0] lat_addr;
    logic [31:0]       lat_wdata;
    logic [3:0]        lat_be;

    logic              req_fire;
    logic              acc_fire;
    logic              acc_write;
    logic [ADDR_W-1:0] acc_addr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_be;
    logic [1:0]        sel;
    logic              dec_err;
    logic              acc_err;
    logic              wr_en;
    logic              reload;
    logic [31:0]       rdata_nxt;

    assign req_ready = (state == IDLE) && !rst;
    assign rsp_valid = (state == RESP);
    assign req_fire  = req_valid && req_ready;

    // With no wait states the access happens on the handshake edge, straight from the request bus.
    assign acc_fire  = (WAIT_CYCLES == 0) ? req_fire
                                          : (state == ACCESS) && (wait_cnt == 4'd0);
    assign acc_write = (WAIT_CYCLES == 0) ? req_write : lat_write;
    assign acc_addr  = (WAIT_CYCLES == 0) ? req_addr  : lat_addr;
    assign acc_wdata = (WAIT_CYCLES == 0) ? req_wdata : lat_wdata;
    assign acc_be    = (WAIT_CYCLES == 0) ? req_be    : lat_be;

    xyz_reg_decode #(
        .ADDR_W (ADDR_W)
    ) u_decode (
        .addr (acc_addr),
        .sel  (sel),
        .err  (dec_err)
    );

    assign acc_err = dec_err || (acc_write && (sel == SEL_ID));
    assign wr_en   = acc_fire && acc_write && !acc_err;
    assign reload  = wr_en && (sel == SEL_CTRL) && acc_be[0] && acc_wdata[0];

    always_comb begin
        rdata_nxt = 32'h0;
        if (!acc_write && !dec_err) begin
            case (sel)
                SEL_R1:  rdata_nxt = r1_q;
                SEL_R2:  rdata_nxt = r2_q;
                SEL_ID:  rdata_nxt = ID_VALUE;
                default: rdata_nxt = 32'h0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wait_cnt  <= 4'd0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= 32'h0;
            lat_be    <= 4'h0;
            r1_q      <= R1_RST;
            r2_q      <= R2_RST;
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_fire) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        wait_cnt  <= 4'(WAIT_CYCLES - 1);
                        state     <= (WAIT_CYCLES == 0) ? RESP : ACCESS;
                    end
                end
                ACCESS: begin
                    if (wait_cnt == 4'd0) state <= RESP;
                    else                  wait_cnt <= wait_cnt - 4'd1;
                end
                RESP: begin
                    if (rsp_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (acc_fire) begin
                rsp_rdata <= rdata_nxt;
                rsp_err   <= acc_err;
            end

            if (reload) begin
                r1_q <= R1_RST;
                r2_q <= R2_RST;
            end else if (wr_en && (sel == SEL_R1)) begin
                r1_q <= apply_be(r1_q, acc_wdata, acc_be);
            end else if (wr_en && (sel == SEL_R2)) begin
                r2_q <= apply_be(r2_q, acc_wdata, acc_be);
            end
        end
    end

endmodule

// File: tb/tb_xyz_reg_responder.sv
// Directed bench: instance a has default parameters, instance b has no wait states and non-zero reset values.
module tb_xyz_reg_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_req_valid = 1'b0, a_req_write = 1'b0, a_rsp_ready = 1'b1;
    logic [7:0]  a_req_addr = 8'h0;
    logic [31:0] a_req_wdata = 32'h0;
    logic [3:0]  a_req_be = 4'h0;
    logic        a_req_ready, a_rsp_valid, a_rsp_err;
    logic [31:0] a_rsp_rdata, a_r1_q, a_r2_q;

    logic        b_req_valid = 1'b0, b_req_write = 1'b0, b_rsp_ready = 1'b1;
    logic [7:0]  b_req_addr = 8'h0;
    logic [31:0] b_req_wdata = 32'h0;
    logic [3:0]  b_req_be = 4'h0;
    logic        b_req_ready, b_rsp_valid, b_rsp_err;
    logic [31:0] b_rsp_rdata, b_r1_q, b_r2_q;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    xyz_reg_responder u_dut_a (
        .clk(clk), .rst(rst),
        .req_valid(a_req_valid), .req_ready(a_req_ready), .req_write(a_req_write),
        .req_addr(a_req_addr), .req_wdata(a_req_wdata), .req_be(a_req_be),
        .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_rdata(a_rsp_rdata),
        .rsp_err(a_rsp_err), .r1_q(a_r1_q), .r2_q(a_r2_q)
    );

    xyz_reg_responder #(
        .R1_RST(32'h1111_2222), .R2_RST(32'h0000_0042), .WAIT_CYCLES(0)
    ) u_dut_b (
        .clk(clk), .rst(rst),
        .req_valid(b_req_valid), .req_ready(b_req_ready), .req_write(b_req_write),
        .req_addr(b_req_addr), .req_wdata(b_req_wdata), .req_be(b_req_be),
        .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_rdata(b_rsp_rdata),
        .rsp_err(b_rsp_err), .r1_q(b_r1_q), .r2_q(b_r2_q)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_req(input bit b, input logic v, input logic w, input logic [7:0] ad,
                           input logic [31:0] wd, input logic [3:0] be);
        if (b) begin
            b_req_valid = v; b_req_write = w; b_req_addr = ad; b_req_wdata = wd; b_req_be = be;
        end else begin
            a_req_valid = v; a_req_write = w; a_req_addr = ad; a_req_wdata = wd; a_req_be = be;
        end
    endtask

    function automatic logic get_ready(input bit b);
        return b ? b_req_ready : a_req_ready;
    endfunction

    function automatic logic get_rv(input bit b);
        return b ? b_rsp_valid : a_rsp_valid;
    endfunction

    // One request/response; lat counts cycles from the handshake cycle to the first rsp_valid cycle.
    task automatic txn(input bit b, input logic w, input logic [7:0] ad, input logic [31:0] wd,
                       input logic [3:0] be, output logic [31:0] rd, output logic e, output int lat);
        int n;
        @(negedge clk);
        set_req(b, 1'b1, w, ad, wd, be);
        n = 0;
        while (!get_ready(b) && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("hs_timeout", 32'(n), 32'd0);
        @(posedge clk);
        #1;
        // Scramble the bus after acceptance; the captured request must be used.
        set_req(b, 1'b0, ~w, ad ^ 8'h04, ~wd, 4'hF);
        lat = 1;
        while (!get_rv(b) && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (lat >= 50) chk("rsp_timeout", 32'(lat), 32'd0);
        rd = b ? b_rsp_rdata : a_rsp_rdata;
        e  = b ? b_rsp_err : a_rsp_err;
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [31:0] rd;
        logic        e;
        int          lat;
        int          n;
        int          seen;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(a_req_ready), 32'd0);
        chk("rst_rsp_valid", 32'(a_rsp_valid), 32'd0);
        chk("rst_rdata", a_rsp_rdata, 32'h0);
        chk("rst_err", 32'(a_rsp_err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("post_rst_ready", 32'(a_req_ready), 32'd1);
        chk("post_rst_r1", a_r1_q, 32'h0);
        chk("post_rst_r2", a_r2_q, 32'h0);
        chk("post_rst_b_r1", b_r1_q, 32'h1111_2222);
        chk("post_rst_b_r2", b_r2_q, 32'h0000_0042);

        txn(0, 1'b0, 8'h00, 32'h0, 4'h0, rd, e, lat);
        chk("rd_r1_init", rd, 32'h0);
        chk("rd_r1_init_err", 32'(e), 32'd0);
        chk("lat_wait1", 32'(lat), 32'd2);
        chk("rsp_drop", 32'(a_rsp_valid), 32'd0);

        txn(0, 1'b1, 8'h00, 32'hDEAD_BEEF, 4'b0101, rd, e, lat);
        chk("wr_r1_rdata", rd, 32'h0);
        chk("wr_r1_err", 32'(e), 32'd0);
        chk("wr_r1_q", a_r1_q, 32'h00AD_00EF);
        txn(0, 1'b0, 8'h00, 32'h0, 4'h0, rd, e, lat);
        chk("rd_r1_merged", rd, 32'h00AD_00EF);
        chk("rd_r1_merged_err", 32'(e), 32'd0);

        txn(0, 1'b1, 8'h04, 32'hFFFF_FFFF, 4'h0, rd, e, lat);
        chk("wr_r2_be0_err", 32'(e), 32'd0);
        chk("wr_r2_be0_q", a_r2_q, 32'h0);

        txn(0, 1'b0, 8'h0C, 32'h0, 4'h0, rd, e, lat);
        chk("rd_id", rd, 32'h5859_5A01);
        chk("rd_id_err", 32'(e), 32'd0);
        txn(0, 1'b1, 8'h0C, 32'h1234_5678, 4'hF, rd, e, lat);
        chk("wr_id_err", 32'(e), 32'd1);
        chk("wr_id_rdata", rd, 32'h0);
        txn(0, 1'b0, 8'h0C, 32'h0, 4'h0, rd, e, lat);
        chk("rd_id_again", rd, 32'h5859_5A01);
        txn(0, 1'b0, 8'h10, 32'h0, 4'h0, rd, e, lat);
        chk("rd_0x10_err", 32'(e), 32'd1);
        chk("rd_0x10_rdata", rd, 32'h0);
        txn(0, 1'b0, 8'h02, 32'h0, 4'h0, rd, e, lat);
        chk("rd_0x02_err", 32'(e), 32'd1);
        txn(0, 1'b0, 8'h08, 32'h0, 4'h0, rd, e, lat);
        chk("rd_ctrl_rdata", rd, 32'h0);
        chk("rd_ctrl_err", 32'(e), 32'd0);
        chk("misc_r1_kept", a_r1_q, 32'h00AD_00EF);

        // Stalled response with a second request waiting behind it.
        @(negedge clk);
        a_rsp_ready = 1'b0;
        set_req(0, 1'b1, 1'b0, 8'h00, 32'h0, 4'h0);
        @(posedge clk);
        #1;
        a_req_addr = 8'h0C;
        n = 0;
        while (!a_rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) chk("stall_rsp_timeout", 32'(n), 32'd0);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(a_rsp_valid), 32'd1);
            chk("stall_rdata", a_rsp_rdata, 32'h00AD_00EF);
            chk("stall_err", 32'(a_rsp_err), 32'd0);
            chk("stall_req_ready", 32'(a_req_ready), 32'd0);
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        a_rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("stall_done_valid", 32'(a_rsp_valid), 32'd0);
        chk("stall_done_ready", 32'(a_req_ready), 32'd1);
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        n = 0;
        while (!a_rsp_valid && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("second_rsp_cycles", 32'(n), 32'd1);
        chk("second_rdata", a_rsp_rdata, 32'h5859_5A01);
        @(posedge clk);
        #1;

        // Zero-wait instance: latency and CTRL reload rules.
        txn(1, 1'b1, 8'h04, 32'h1234_5678, 4'hF, rd, e, lat);
        chk("b_lat_wait0", 32'(lat), 32'd1);
        chk("b_wr_r2_q", b_r2_q, 32'h1234_5678);
        txn(1, 1'b1, 8'h00, 32'hCAFE_F00D, 4'hF, rd, e, lat);
        chk("b_wr_r1_q", b_r1_q, 32'hCAFE_F00D);
        txn(1, 1'b1, 8'h08, 32'h0000_0001, 4'b0010, rd, e, lat);
        chk("b_ctrl_be_off_r2", b_r2_q, 32'h1234_5678);
        txn(1, 1'b1, 8'h08, 32'hFFFF_FFFE, 4'hF, rd, e, lat);
        chk("b_ctrl_bit0_clr_r1", b_r1_q, 32'hCAFE_F00D);
        txn(1, 1'b1, 8'h08, 32'h0000_0001, 4'b0001, rd, e, lat);
        chk("b_reload_err", 32'(e), 32'd0);
        chk("b_reload_r2", b_r2_q, 32'h0000_0042);
        chk("b_reload_r1", b_r1_q, 32'h1111_2222);

        // Reset while a write sits in ACCESS.
        @(negedge clk);
        set_req(0, 1'b1, 1'b1, 8'h00, 32'hFFFF_FFFF, 4'hF);
        @(posedge clk);
        #1;
        a_req_valid = 1'b0;
        rst = 1'b1;
        #1;
        chk("mid_rst_r1", a_r1_q, 32'h0);
        chk("mid_rst_valid", 32'(a_rsp_valid), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (5) begin
            @(posedge clk);
            #1;
            if (a_rsp_valid) seen++;
        end
        chk("mid_rst_no_rsp", 32'(seen), 32'd0);
        chk("mid_rst_r1_after", a_r1_q, 32'h0);
        chk("mid_rst_idle", 32'(a_req_ready), 32'd1);
        txn(0, 1'b0, 8'h00, 32'h0, 4'h0, rd, e, lat);
        chk("mid_rst_rd_r1", rd, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/xyz_reg_responder.md
Name: xyz_reg_responder

Overview:
- Frontdoor register-bus responder for the XYZ block's two 32-bit registers (R1, R2); it is the bus-side counterpart of backdoor-accessed register storage.
- It accepts single read/write requests from the register-layer bus agent over a valid/ready request channel, with programmable wait states.
- It returns read data and error status on a valid/ready response channel.
- It supports a software-triggered reload of the reset values.

Parameters:
- ADDR_W, 8, request address width; only byte addresses 0x00-0x0C decode.
- R1_RST, 32'h0000_0000, R1 reset/reload value.
- R2_RST, 32'h0000_0000, R2 reset/reload value.
- WAIT_CYCLES, 1, cycles spent in ACCESS before the response (0..15).
- ID_VALUE, 32'h5859_5A01, read-only contents of the ID register.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid && req_ready
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address, word aligned
- req_wdata  in  32  write data
- req_be  in  4  byte enables for writes; bit n covers bits [8n+7:8n]
- rsp_valid  out  1  response present
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready
- rsp_rdata  out  32  read data; 0 for writes and errors
- rsp_err  out  1  decode or access error
- r1_q  out  32  current R1 value
- r2_q  out  32  current R2 value

Behaviour:
- Register map:
  - 0x00 R1: RW, byte-enabled.
  - 0x04 R2: RW, byte-enabled.
  - 0x08 CTRL: write-only. Bit0 = 1 reloads R1/R2 with R1_RST/R2_RST. Reads return 0 with err = 0.
  - 0x0C ID: RO. A write gives err = 1 and has no effect.
  - Any other address or misaligned address (addr[1:0] != 0): err = 1, no side effect.
- Reset (async, rst = 1):
  - FSM to IDLE.
  - r1_q = R1_RST, r2_q = R2_RST.
  - req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0.
  - The first cycle after rst deasserts is IDLE with req_ready = 1.
- FSM IDLE:
  - req_ready = 1.
  - On handshake: latch write, addr, wdata and be. Go to ACCESS, or straight to RESP if WAIT_CYCLES = 0.
- FSM ACCESS:
  - req_ready = 0.
  - A 4-bit counter loads WAIT_CYCLES-1 and decrements.
  - At 0, perform the access on the same edge and go to RESP.
  - Writes to R1/R2 update only enabled bytes. be = 0 is a legal no-op with err = 0.
  - Read data is sampled at this edge, so it reflects any write performed earlier.
- FSM RESP:
  - rsp_valid = 1, with rdata and err stable until handshake.
  - On rsp_ready: go to IDLE, rsp_valid deasserts the next cycle.
  - No new request is accepted while in RESP; there is a single outstanding transaction.
- Latency: request handshake to rsp_valid = WAIT_CYCLES + 1 cycles. Minimum throughput is one transaction per WAIT_CYCLES + 2 cycles.
- CTRL reload:
  - Occurs on the access edge.
  - If CTRL bit0 = 1 with be[0] = 1, both registers reload.
  - Other CTRL bits are ignored.
- Write data is captured at request handshake. req_* changes after acceptance have no effect.
- Reset mid-transaction: the transaction is discarded, no response is issued, and registers return to their reset values.
- rsp_ready held high before rsp_valid is legal. The response still lasts at least one cycle.

Decomposition:
- Package xyz_reg_pkg:
  - Address constants ADDR_R1/ADDR_R2/ADDR_CTRL/ADDR_ID.
  - State enum typedef {IDLE, ACCESS, RESP}.
  - Helper function apply_be(old, new, be) returning the byte-merged word.
- Optional sub-module xyz_reg_decode: combinational address/alignment decode producing a register select and err. Everything else stays in the top.

Test Plan:
- Reset with defaults → r1_q = 0, r2_q = 0, req_ready = 1 one cycle after rst falls. Read 0x00 → rdata = 0, err = 0, rsp_valid 2 cycles after handshake (WAIT_CYCLES = 1).
- Write 0x00 data 0xDEADBEEF, be = 4'b0101 over R1 = 0 → r1_q = 0x00AD00EF. A read returns the same value, err = 0.
- Write R2 = 0x12345678, then write CTRL = 0x1 with R2_RST = 0x42 → r2_q = 0x42 on the access edge, R1 also reloaded.
- Read 0x0C → rdata = 0x58595A01. Write 0x0C → err = 1, rdata = 0, ID unchanged. Read 0x10 or 0x02 → err = 1.
- Hold rsp_ready = 0 for 5 cycles during a read → rsp_valid, rdata and err stable, req_ready = 0. A second request presented meanwhile is accepted only after returning to IDLE.
- Assert rst during ACCESS of a write to R1 = 0xFFFFFFFF → no response, r1_q = R1_RST, FSM IDLE. Repeat with WAIT_CYCLES = 0 → response 1 cycle after handshake.
